// File: rtl/mux_n_registrado_pkg.sv
// Shared definitions for the registered N:1 multiplexer: index width helper and mode codes.
package proc_pkg_mux;

    localparam logic MODO_DIRETO = 1'b0;
    localparam logic MODO_RR     = 1'b1;

    // A 1-channel index still needs one bit so that every port has a legal width.
    function automatic int sel_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_n_registrado_if.sv
// Producer/consumer bundle of the registered multiplexer; slave is the mux side.
interface mux_n_registrado_if
    import proc_pkg_mux::*;
#(
    parameter int LARGURA = 4,
    parameter int CANAIS  = 4
);
    localparam int SEL_W = sel_w(CANAIS);

    logic [CANAIS*LARGURA-1:0] Entradas;
    logic [CANAIS-1:0]         Valido_in;
    logic [CANAIS-1:0]         Pronto_out;
    logic                      Modo;
    logic [SEL_W-1:0]          Controle;
    logic [LARGURA-1:0]        Resultado;
    logic [SEL_W-1:0]          Canal_out;
    logic                      Valido_out;
    logic                      Pronto_in;

    modport slave (
        input  Entradas,
        input  Valido_in,
        output Pronto_out,
        input  Modo,
        input  Controle,
        output Resultado,
        output Canal_out,
        output Valido_out,
        input  Pronto_in
    );

    modport master (
        output Entradas,
        output Valido_in,
        input  Pronto_out,
        output Modo,
        output Controle,
        input  Resultado,
        input  Canal_out,
        input  Valido_out,
        output Pronto_in
    );

endinterface

// File: rtl/mux_n_registrado_arbitro_rr.sv
// Combinational round-robin picker: first request strictly after ptr, wrapping around.
module arbitro_rr
    import proc_pkg_mux::*;
#(
    parameter int CANAIS = 4,
    localparam int SEL_W = sel_w(CANAIS)
) (
    input  logic [CANAIS-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [CANAIS-1:0] grant,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        idx   = '0;
        // Offsets 1..CANAIS visit every channel once, ending on ptr itself.
        for (int k = 1; k <= CANAIS; k++) begin
            c = (int'(ptr) + k) % CANAIS;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = SEL_W'(c);
            end
        end
    end

    for (genvar gi = 0; gi < CANAIS; gi++) begin : g_grant
        assign grant[gi] = found && (idx == SEL_W'(gi));
    end

endmodule

// File: rtl/mux_n_registrado.sv
// Registered N:1 multiplexer with direct or round-robin selection and valid/ready output.
module mux_n_registrado
    import proc_pkg_mux::*;
#(
    parameter int LARGURA = 4,
    parameter int CANAIS  = 4,
    localparam int SEL_W  = sel_w(CANAIS)
) (
    input  logic                Clock,
    input  logic                Reset,
    mux_n_registrado_if.slave   bus
);

    logic [LARGURA-1:0] resultado_reg, resultado_next;
    logic [SEL_W-1:0]   canal_reg, canal_next;
    logic               valido_reg, valido_next;
    logic [SEL_W-1:0]   ptr_reg, ptr_next;

    logic               carga;
    logic               concedido;
    logic [CANAIS-1:0]  dir_onehot;
    logic               dir_ok;
    logic [CANAIS-1:0]  rr_grant;
    logic [SEL_W-1:0]   rr_idx;
    logic               rr_found;
    logic [CANAIS-1:0]  cand_onehot;
    logic [SEL_W-1:0]   cand_idx;
    logic               cand_ok;
    logic [LARGURA-1:0] cand_word;

    // An out-of-range Controle matches no channel, so it simply yields no grant.
    for (genvar gi = 0; gi < CANAIS; gi++) begin : g_direto
        assign dir_onehot[gi] = (bus.Controle == SEL_W'(gi)) && bus.Valido_in[gi];
    end
    assign dir_ok = |dir_onehot;

    arbitro_rr #(
        .CANAIS (CANAIS)
    ) u_arbitro (
        .req   (bus.Valido_in),
        .ptr   (ptr_reg),
        .grant (rr_grant),
        .idx   (rr_idx),
        .found (rr_found)
    );

    always_comb begin
        cand_onehot = dir_onehot;
        cand_idx    = bus.Controle;
        cand_ok     = dir_ok;
        if (bus.Modo == MODO_RR) begin
            cand_onehot = rr_grant;
            cand_idx    = rr_idx;
            cand_ok     = rr_found;
        end
    end

    always_comb begin
        cand_word = '0;
        for (int i = 0; i < CANAIS; i++) begin
            if (cand_onehot[i]) begin
                cand_word = bus.Entradas[i*LARGURA +: LARGURA];
            end
        end
    end

    // No strobe while reset is held, so a producer never loses a word to a discarded load.
    assign carga          = !valido_reg || bus.Pronto_in;
    assign concedido      = Reset && carga && cand_ok;
    assign bus.Pronto_out = concedido ? cand_onehot : '0;

    always_comb begin
        resultado_next = resultado_reg;
        canal_next     = canal_reg;
        valido_next    = valido_reg;
        ptr_next       = ptr_reg;
        if (concedido) begin
            resultado_next = cand_word;
            canal_next     = cand_idx;
            valido_next    = 1'b1;
            if (bus.Modo == MODO_RR) begin
                ptr_next = cand_idx;
            end
        end else if (carga) begin
            valido_next = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            resultado_reg <= '0;
            canal_reg     <= '0;
            valido_reg    <= 1'b0;
            ptr_reg       <= SEL_W'(CANAIS - 1);
        end else begin
            resultado_reg <= resultado_next;
            canal_reg     <= canal_next;
            valido_reg    <= valido_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign bus.Resultado  = resultado_reg;
    assign bus.Canal_out  = canal_reg;
    assign bus.Valido_out = valido_reg;

endmodule

// File: doc/mux_n_registrado.md
Name: mux_n_registrado

Overview:
Parametrised successor of the 2:1 data-path multiplexer in the single-cycle processor. It selects one of CANAIS input channels of LARGURA bits and captures the chosen word in an output register with a valid/ready handshake. Two selection modes: direct (Controle picks the channel) and round-robin (fair scan over channels with pending data). It sits between producers that share one consumer, such as write-back sources or bus masters, and the consumer stage.

Parameters:
LARGURA, 4, data width per channel in bits
CANAIS, 4, number of input channels, at least 2
SEL_W, $clog2(CANAIS), width of channel index (derived, not overridden)

Ports:
Clock  in  1  single clock; all state updates on the rising edge
Reset  in  1  reset, synchronous and active-low
Entradas  in  CANAIS*LARGURA  channel i occupies bits [i*LARGURA +: LARGURA]
Valido_in  in  CANAIS  channel i has a word pending
Pronto_out  out  CANAIS  one-hot accept strobe to channel i (combinational)
Modo  in  1  0 = direct select, 1 = round-robin
Controle  in  SEL_W  channel index in direct mode; ignored in round-robin mode
Resultado  out  LARGURA  registered selected word
Canal_out  out  SEL_W  index of the channel that supplied Resultado
Valido_out  out  1  Resultado holds a word
Pronto_in  in  1  consumer accepts the word this cycle

Behaviour:
- Reset (Reset==0 at a rising edge): Resultado=0, Canal_out=0, Valido_out=0, RR pointer=CANAIS-1, so channel 0 gets first priority. Reset asserted mid-transfer discards the held word with no accept strobe.
- Load enable: carga = !Valido_out || Pronto_in. Word transfer out of the block happens when Valido_out && Pronto_in.
- Candidate in direct mode: Controle, only when Controle<CANAIS and Valido_in[Controle]=1. Otherwise there is no grant. An out-of-range Controle is never an error; it simply produces no grant.
- Candidate in round-robin mode: the first i with Valido_in[i]=1, searching from (ptr+1) mod CANAIS upward with wrap-around.
- Grant: concedido = carga && a candidate exists. Pronto_out is one-hot on the candidate when concedido, otherwise all zeros. Pronto_out never depends on Pronto_out, and there is no combinational path from Pronto_out back into selection.
- On a grant at a rising edge:
  - Resultado is loaded with the candidate word.
  - Canal_out is loaded with the candidate index.
  - Valido_out is set to 1.
  - In round-robin mode, ptr is loaded with the candidate index.
- Latency: 1 cycle from grant to Valido_out.
- Throughput: 1 word/cycle when Pronto_in is held at 1. A simultaneous output transfer and new grant in the same cycle is legal and required.
- If carga=1 and there is no candidate, Valido_out clears when the current word is taken. Resultado and Canal_out keep their last value.
- Stall (Valido_out=1, Pronto_in=0): Resultado, Canal_out and Valido_out stay stable. Pronto_out is all zeros. Inputs may change freely.
- ptr changes only on a grant in round-robin mode. Direct-mode grants leave ptr untouched.
- A Modo change takes effect at the next selection. The held word is unaffected.
- With a single requester, that requester is granted every eligible cycle regardless of ptr.

Decomposition:
- Package proc_pkg_mux holds:
  - the function sel_w(n) = $clog2(n) with a minimum of 1;
  - localparams MODO_DIRETO=1'b0 and MODO_RR=1'b1.
- Sub-module arbitro_rr (CANAIS param) is natural: it is purely combinational, takes the request vector and ptr, and outputs the one-hot grant plus the index.
- The top module owns ptr, the output register and the handshake.

Test Plan:
All scenarios use LARGURA=4, CANAIS=4.
1. Reset: hold Reset=0 for 2 cycles with all Valido_in=1 -> Valido_out=0, Resultado=0000, Pronto_out=0000. After release, channel 0 is granted first in round-robin mode.
2. Direct mode: Entradas ch0=1111, ch1=0000; Controle toggles 0/1 every cycle; Valido_in=0011; Pronto_in=1 -> Resultado follows one cycle later (1111, 0000, ...) and Canal_out matches.
3. Direct mode, out of range: CANAIS=3 build, Controle=3 -> Pronto_out=000 and Valido_out drops to 0 after the current word is taken.
4. Round-robin: Valido_in=1111 held, Pronto_in=1 -> Canal_out sequence 0,1,2,3,0. With Valido_in=0101 -> sequence 0,2,0,2.
5. Back-pressure: Pronto_in=0 for 3 cycles while Entradas change -> Resultado, Canal_out and Valido_out are unchanged and Pronto_out=0000. When Pronto_in returns to 1, the held word transfers and a new grant is made in the same cycle.
6. Reset mid-operation: Valido_out=1 and Pronto_in=0, then Reset=0 for 1 cycle -> Valido_out=0 and ptr restarts, so the next round-robin grant goes to the lowest valid channel.
